// File: rtl/noc_vc_buffer_if.sv
// Upstream/downstream handshake bundle for noc_vc_buffer.
// slave is the buffer's view; master is the traffic side.
interface noc_vc_buffer_if #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_VC     = 2
);
  logic                  si;
  logic [DATA_WIDTH-1:0] di;
  logic [NUM_VC-1:0]     ri;
  logic                  so;
  logic [DATA_WIDTH-1:0] dout;
  logic [NUM_VC-1:0]     ro;

  modport master (
    output si, di, ro,
    input  ri, so, dout
  );

  modport slave (
    input  si, di, ro,
    output ri, so, dout
  );
endinterface

// File: rtl/noc_vc_buffer.sv
// Per-VC FIFO buffer with round-robin output arbiter.
// Define NOC_VC_BUFFER_STATS_EN for pkt_cnt/err_ovf stats.
module noc_vc_buffer #(
  parameter int DATA_WIDTH = 64,
  parameter int NUM_VC     = 2,
  parameter int DEPTH      = 2
) (
  input  logic clk,
  input  logic reset,
  output logic polarity,
  noc_vc_buffer_if.slave bus,
  output logic [NUM_VC*($clog2(DEPTH)+1)-1:0] occ,
  output logic [15:0] pkt_cnt,
  output logic        err_ovf
);
  localparam int VCW = (NUM_VC > 1) ? $clog2(NUM_VC) : 1;
  localparam int PW  = $clog2(DEPTH);
  localparam int CW  = PW + 1;

  typedef logic [VCW-1:0] vc_t;

  logic [DATA_WIDTH-1:0] mem [NUM_VC][DEPTH];
  logic [PW-1:0] wptr [NUM_VC];
  logic [PW-1:0] rptr [NUM_VC];
  logic [CW-1:0] cnt  [NUM_VC];

  vc_t vc;
  vc_t rr;
  vc_t gnt_idx;
  logic gnt_vld;
  logic [NUM_VC-1:0] ri_w;
  logic [NUM_VC-1:0] push;
  logic [NUM_VC-1:0] pop;
  logic [NUM_VC-1:0] elig;
  logic so_q;
  logic [DATA_WIDTH-1:0] dout_q;

  assign vc = bus.di[DATA_WIDTH-1 -: VCW];

  // ready comes from the registered count only
  always_comb begin
    ri_w = '0;
    push = '0;
    elig = '0;
    for (int v = 0; v < NUM_VC; v++) begin
      ri_w[v] = reset && (cnt[v] != CW'(DEPTH));
      elig[v] = (cnt[v] != '0) && bus.ro[v];
      push[v] = bus.si && (vc == vc_t'(v)) && ri_w[v];
    end
  end

  always_comb begin
    gnt_vld = 1'b0;
    gnt_idx = rr;
    pop     = '0;
    for (int i = 0; i < NUM_VC; i++) begin
      if (!gnt_vld && elig[rr + vc_t'(i)]) begin
        gnt_vld = 1'b1;
        gnt_idx = rr + vc_t'(i);
      end
    end
    if (gnt_vld) pop[gnt_idx] = 1'b1;
  end

  always_ff @(posedge clk) begin
    for (int v = 0; v < NUM_VC; v++) begin
      if (push[v]) mem[v][wptr[v]] <= bus.di;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rr       <= '0;
      so_q     <= 1'b0;
      dout_q   <= '0;
      polarity <= 1'b0;
      for (int v = 0; v < NUM_VC; v++) begin
        wptr[v] <= '0;
        rptr[v] <= '0;
        cnt[v]  <= '0;
      end
    end else begin
      polarity <= ~polarity;
      so_q     <= gnt_vld;
      if (gnt_vld) begin
        dout_q <= mem[gnt_idx][rptr[gnt_idx]];
        rr     <= gnt_idx + vc_t'(1);
      end
      for (int v = 0; v < NUM_VC; v++) begin
        if (push[v]) wptr[v] <= wptr[v] + PW'(1);
        if (pop[v])  rptr[v] <= rptr[v] + PW'(1);
        if (push[v] && !pop[v])
          cnt[v] <= cnt[v] + CW'(1);
        else if (pop[v] && !push[v])
          cnt[v] <= cnt[v] - CW'(1);
      end
    end
  end

  assign bus.ri   = ri_w;
  assign bus.so   = so_q;
  assign bus.dout = dout_q;

  for (genvar g = 0; g < NUM_VC; g++) begin : g_occ
    assign occ[g*CW +: CW] = cnt[g];
  end

`ifdef NOC_VC_BUFFER_STATS_EN
  logic        accept;
  logic        drop;
  logic [15:0] pkt_q;
  logic        ovf_q;

  assign accept = |push;
  assign drop   = bus.si && !ri_w[vc];

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pkt_q <= '0;
      ovf_q <= 1'b0;
    end else begin
      if (accept) pkt_q <= pkt_q + 16'd1;
      if (drop)   ovf_q <= 1'b1;
    end
  end

  assign pkt_cnt = pkt_q;
  assign err_ovf = ovf_q;
`else
  assign pkt_cnt = '0;
  assign err_ovf = 1'b0;
`endif
endmodule

// File: tb/tb_noc_vc_buffer.sv
// Bench for noc_vc_buffer: vector table, corner sequences
// and random traffic against a queue-based reference model.
module tb_noc_vc_buffer;
  localparam int DW = 64;
  localparam int NV = 2;
  localparam int DP = 4;
`ifdef NOC_VC_BUFFER_STATS_EN
  localparam bit STATS = 1'b1;
`else
  localparam bit STATS = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic        polarity;
  logic [5:0]  occ;
  logic [15:0] pkt_cnt;
  logic        err_ovf;

  noc_vc_buffer_if #(.DATA_WIDTH(DW), .NUM_VC(NV)) bus ();

  noc_vc_buffer #(
    .DATA_WIDTH(DW),
    .NUM_VC(NV),
    .DEPTH(DP)
  ) dut (
    .clk(clk),
    .reset(reset),
    .polarity(polarity),
    .bus(bus.slave),
    .occ(occ),
    .pkt_cnt(pkt_cnt),
    .err_ovf(err_ovf)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [63:0] mq [2][$];
  int          m_rr;
  bit          m_so;
  logic [63:0] m_do;
  bit          m_pol;
  int          m_acc;
  bit          m_drop;

  typedef struct {
    bit          si;
    logic [63:0] di;
    logic [1:0]  ro;
    bit          so;
    logic [63:0] dout;
    logic [1:0]  ri;
    logic [5:0]  occ;
  } vec_t;

  vec_t tbl [12];
  logic [63:0] rrx [6];

  task automatic chk(input string name,
                     input logic [63:0] act,
                     input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h @%0t",
               name, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    mq[0].delete();
    mq[1].delete();
    m_rr   = 0;
    m_so   = 1'b0;
    m_do   = '0;
    m_pol  = 1'b0;
    m_acc  = 0;
    m_drop = 1'b0;
  endtask

  task automatic model_edge();
    bit [1:0] rdy;
    int g;
    int v;
    int c;
    for (int k = 0; k < NV; k++)
      rdy[k] = (mq[k].size() != DP);
    g = -1;
    for (int k = 0; k < NV; k++) begin
      c = (m_rr + k) % NV;
      if (g < 0 && mq[c].size() > 0 && bus.ro[c])
        g = c;
    end
    if (g >= 0) begin
      m_do = mq[g].pop_front();
      m_so = 1'b1;
      m_rr = (g + 1) % NV;
    end else begin
      m_so = 1'b0;
    end
    if (bus.si) begin
      v = int'(bus.di[63]);
      if (rdy[v]) begin
        mq[v].push_back(bus.di);
        m_acc++;
      end else begin
        m_drop = 1'b1;
      end
    end
    m_pol = ~m_pol;
  endtask

  task automatic compare_all();
    logic [1:0]  e_ri;
    logic [5:0]  e_occ;
    logic [15:0] e_pkt;
    e_ri[0] = (mq[0].size() != DP);
    e_ri[1] = (mq[1].size() != DP);
    e_occ = {3'(mq[1].size()), 3'(mq[0].size())};
    e_pkt = STATS ? 16'(m_acc % 65536) : 16'd0;
    chk("so", 64'(bus.so), 64'(m_so));
    chk("dout", bus.dout, m_do);
    chk("ri", 64'(bus.ri), 64'(e_ri));
    chk("occ", 64'(occ), 64'(e_occ));
    chk("polarity", 64'(polarity), 64'(m_pol));
    chk("pkt_cnt", 64'(pkt_cnt), 64'(e_pkt));
    chk("err_ovf", 64'(err_ovf), 64'(STATS & m_drop));
  endtask

  task automatic cycle(input bit s,
                       input logic [63:0] d,
                       input logic [1:0] r);
    bus.si = s;
    bus.di = d;
    bus.ro = r;
    @(posedge clk);
    model_edge();
    #1;
    compare_all();
  endtask

  task automatic check_in_reset();
    chk("rst_so", 64'(bus.so), 64'd0);
    chk("rst_ri", 64'(bus.ri), 64'd0);
    chk("rst_occ", 64'(occ), 64'd0);
    chk("rst_pol", 64'(polarity), 64'd0);
    chk("rst_pkt", 64'(pkt_cnt), 64'd0);
    chk("rst_ovf", 64'(err_ovf), 64'd0);
  endtask

  task automatic pulse_reset();
    reset = 1'b0;
    model_reset();
    #1;
    check_in_reset();
    @(posedge clk);
    #3;
    reset = 1'b1;
    #1;
    compare_all();
  endtask

  initial begin
    logic [63:0] d;

    tbl[0]  = '{1, 64'h0000_0101_0000_0000, 2'b11,
                0, 64'h0, 2'b11, 6'o01};
    tbl[1]  = '{0, 64'h0, 2'b11,
                1, 64'h0000_0101_0000_0000, 2'b11, 6'o00};
    tbl[2]  = '{1, 64'h8000_0000_0000_0001, 2'b00,
                0, 64'h0000_0101_0000_0000, 2'b11, 6'o10};
    tbl[3]  = '{1, 64'h8000_0000_0000_0002, 2'b00,
                0, 64'h0000_0101_0000_0000, 2'b11, 6'o20};
    tbl[4]  = '{1, 64'h8000_0000_0000_0003, 2'b00,
                0, 64'h0000_0101_0000_0000, 2'b11, 6'o30};
    tbl[5]  = '{1, 64'h8000_0000_0000_0004, 2'b00,
                0, 64'h0000_0101_0000_0000, 2'b01, 6'o40};
    tbl[6]  = '{1, 64'h8000_0000_0000_0005, 2'b00,
                0, 64'h0000_0101_0000_0000, 2'b01, 6'o40};
    tbl[7]  = '{0, 64'h0, 2'b10,
                1, 64'h8000_0000_0000_0001, 2'b11, 6'o30};
    tbl[8]  = '{0, 64'h0, 2'b10,
                1, 64'h8000_0000_0000_0002, 2'b11, 6'o20};
    tbl[9]  = '{0, 64'h0, 2'b10,
                1, 64'h8000_0000_0000_0003, 2'b11, 6'o10};
    tbl[10] = '{0, 64'h0, 2'b10,
                1, 64'h8000_0000_0000_0004, 2'b11, 6'o00};
    tbl[11] = '{0, 64'h0, 2'b10,
                0, 64'h8000_0000_0000_0004, 2'b11, 6'o00};

    rrx[0] = 64'h0000_0000_0000_00A0;
    rrx[1] = 64'h8000_0000_0000_00B0;
    rrx[2] = 64'h0000_0000_0000_00A1;
    rrx[3] = 64'h8000_0000_0000_00B1;
    rrx[4] = 64'h0000_0000_0000_00A2;
    rrx[5] = 64'h8000_0000_0000_00B2;

    bus.si = 1'b0;
    bus.di = '0;
    bus.ro = 2'b00;
    model_reset();
    #12;
    check_in_reset();
    chk("rst_dout", bus.dout, 64'd0);
    @(negedge clk);
    reset = 1'b1;
    #1;
    chk("rel_ri", 64'(bus.ri), 64'h3);
    chk("rel_pol", 64'(polarity), 64'd0);
    compare_all();
    for (int i = 1; i <= 3; i++) begin
      cycle(1'b0, 64'h0, 2'b00);
      chk("pol_seq", 64'(polarity), 64'(i % 2));
    end

    for (int i = 0; i < 12; i++) begin
      cycle(tbl[i].si, tbl[i].di, tbl[i].ro);
      chk("tv_so", 64'(bus.so), 64'(tbl[i].so));
      chk("tv_dout", bus.dout, tbl[i].dout);
      chk("tv_ri", 64'(bus.ri), 64'(tbl[i].ri));
      chk("tv_occ", 64'(occ), 64'(tbl[i].occ));
      if (i == 1)
        chk("tv_pkt1", 64'(pkt_cnt), STATS ? 64'd1 : 64'd0);
      if (i == 6)
        chk("tv_ovf", 64'(err_ovf), 64'(STATS));
    end

    for (int i = 0; i < 3; i++) begin
      cycle(1'b1, 64'hA0 + 64'(i), 2'b00);
      cycle(1'b1, 64'h8000_0000_0000_00B0 + 64'(i), 2'b00);
    end
    for (int k = 0; k < 6; k++) begin
      cycle(1'b0, 64'h0, 2'b11);
      chk("rr_so", 64'(bus.so), 64'd1);
      chk("rr_dout", bus.dout, rrx[k]);
    end

    for (int i = 0; i < 3; i++)
      cycle(1'b1, 64'hC0 + 64'(i), 2'b00);
    cycle(1'b0, 64'h0, 2'b11);
    chk("mid_so", 64'(bus.so), 64'd1);
    #2;
    pulse_reset();
    for (int i = 0; i < 4; i++) begin
      cycle(1'b0, 64'h0, 2'b11);
      chk("post_rst_so", 64'(bus.so), 64'd0);
    end

    for (int n = 0; n < 2000; n++) begin
      d = {$urandom(), $urandom()};
      cycle($urandom_range(0, 99) < 70, d,
            2'($urandom_range(0, 3)));
    end

    pulse_reset();
    for (int n = 0; n < 70000; n++) begin
      d = 64'(n);
      d[63] = n[0];
      cycle(1'b1, d, 2'b11);
    end
    chk("pkt_70000", 64'(pkt_cnt),
        STATS ? 64'd4464 : 64'd0);
    chk("ovf_70000", 64'(err_ovf), 64'd0);

    $display("Simulation finished: %0d checks, %0d errors",
             checks, errors);
    $finish;
  end
endmodule
